fb_port_arbiter: RTL and testbench
==================================

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 18, framebuffer address width.
- FB_SIZE, 122400, valid locations (408x300, 1 bit each).
- FIFO_DEPTH, 4, write-queue entries (power of 2).
- STARVE_LIMIT, 8, consecutive write-denied cycles before a forced write grant.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high.
- wr_req, in, 1, write request, one-cycle pulse per pixel.
- wr_addr, in, ADDR_W, write address.
- wr_data, in, 1, write pixel.
- wr_full, out, 1, write queue holds FIFO_DEPTH entries.
- rd_req, in, 1, read request, held until rd_ack.
- rd_addr, in, ADDR_W, read address, stable while rd_req is high.
- rd_ack, out, 1, read accepted this cycle.
- rd_valid, out, 1, rd_data valid, one-cycle pulse.
- rd_data, out, 1, read pixel.
- ram_addr, out, ADDR_W, single-port RAM address, registered.
- ram_data, out, 1, RAM write data, registered.
- ram_wren, out, 1, RAM write enable, registered.
- ram_q, in, 1, RAM read data, valid one edge after ram_addr is sampled.
- ovf, out, 1, sticky flag: a write was dropped.
- fifo_level, out, 3, current queue occupancy (0..FIFO_DEPTH).

Function
REQ-003 Enqueue: wr_req=1, wr_full=0 and wr_addr<FB_SIZE push {wr_addr,wr_data}; occupancy becomes visible on fifo_level the next cycle.
REQ-004 wr_req=1 with wr_full=1 drops the write and sets ovf; the decision uses pre-edge occupancy, so a same-cycle dequeue does not free the slot.
REQ-005 wr_req=1 with wr_addr>=FB_SIZE is silently discarded: not queued, ovf unchanged.
REQ-006 Each cycle the arbiter grants at most one of READ, WRITE or NONE; the grant is a combinational decision from the current inputs and state.
REQ-007 Grant rules:
- READ if rd_req=1 and the forced-write condition is false.
- Else WRITE if the queue is non-empty.
- Else NONE.
REQ-008 Forced-write condition: starve_cnt==STARVE_LIMIT-1 and queue non-empty.
REQ-009 starve_cnt (4 bits):
- Increments on cycles where the queue is non-empty and the grant is READ.
- Clears to 0 on a WRITE grant or when the queue is empty.
- Saturates at STARVE_LIMIT-1.
REQ-010 READ grant:
- rd_ack=1 in the same cycle.
- Next edge: ram_addr<=rd_addr, ram_wren<=0.
REQ-011 WRITE grant:
- Pop the head entry.
- Next edge: ram_addr<=head addr, ram_data<=head data, ram_wren<=1.
REQ-012 NONE grant: ram_wren<=0; ram_addr and ram_data hold.
REQ-013 Read latency is fixed: rd_valid pulses exactly 3 cycles after the rd_ack cycle, with rd_data registered from ram_q. The read pipeline is a 3-stage valid shift plus an out-of-range marker.
REQ-014 Reads accepted back-to-back (one per cycle) return in order, one rd_valid per cycle.
REQ-015 rd_req with rd_addr>=FB_SIZE is acked normally, does not access RAM (ram_wren<=0, ram_addr holds), and returns rd_data=0 at the same latency.
REQ-016 No write-to-read forwarding: a read of an address with a queued write returns the RAM contents at the read access. Callers rely on raster separation.
REQ-017 Queue order is strictly FIFO. Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo depth; the count register is one bit wider.
REQ-018 Simultaneous enqueue and dequeue with 0<occupancy<FIFO_DEPTH leaves occupancy unchanged.
REQ-019 Enqueue into an empty queue is not eligible for grant in the same cycle; the earliest RAM write is 2 edges after wr_req.
REQ-020 wr_full = (occupancy==FIFO_DEPTH); fifo_level = occupancy; both are registered-state derived, with no combinational path from inputs.
REQ-021 ovf clears only on reset.

Reset
REQ-022 While reset=1 at an edge, the following clear:
- queue pointers and count to 0
- starve_cnt and the read pipeline to 0
- ovf, rd_valid, rd_data, ram_wren, ram_data to 0
- ram_addr to 0
REQ-023 Grant is NONE and rd_ack=0 while reset=1.
REQ-024 Reset mid-operation discards queued writes and in-flight reads: no rd_valid for reads acked before reset, and ram_wren=0 the cycle after the reset edge.

Verification
REQ-025 Single write then read: write addr 100 data 1, idle 3 cycles, read addr 100 → rd_ack same cycle, rd_valid 3 cycles later with rd_data=1; ram_wren pulses once with ram_addr=100.
REQ-026 Overflow: rd_req held high and 5 write pulses on consecutive cycles → fifo_level reaches 4, wr_full=1, the 5th write is dropped, ovf=1 and stays 1 until reset.
REQ-027 Starvation: rd_req held continuously, 1 queued write → 7 READ grants, then 1 WRITE grant on the 8th cycle (rd_ack=0 that cycle), then READ resumes; rd_valid count equals rd_ack count.
REQ-028 Out-of-range: read addr 122400 → rd_valid after 3 cycles, rd_data=0, no RAM access; write addr 122400 → fifo_level stays 0, ovf stays 0.
REQ-029 Reset mid-flight: 2 reads acked and 3 writes queued, reset asserted one cycle → no rd_valid afterwards, fifo_level=0, ram_wren=0, ovf=0.
REQ-030 Ordering: writes to addrs 10,11,12 with data 1,0,1 and no reads → ram_wren pulses on consecutive cycles with ram_addr 10,11,12 and ram_data 1,0,1.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: queues 1-bit pixel writes and shares one single-port RAM
// between a read client (priority) and the write queue, with a starvation guard.
module fb_port_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int FB_SIZE      = 122400,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_full,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic              rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              ram_wren,
  input  logic              ram_q,
  output logic              ovf,
  output logic [2:0]        fifo_level
);

  localparam int                PTR_W      = $clog2(FIFO_DEPTH);
  localparam int                CNT_W      = PTR_W + 1;
  localparam logic [ADDR_W-1:0] FB_LIM     = ADDR_W'(FB_SIZE);
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0]        STARVE_MAX = 4'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_READ,
    GNT_WRITE
  } grant_t;

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic              r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_starve;
  logic [2:0]        r_vld;
  logic [1:0]        r_oor;
  logic              r_rd_data;
  logic              r_ovf;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_data;
  logic              r_ram_wren;

  grant_t            w_grant;
  logic              w_empty;
  logic              w_full;
  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_force;
  logic              w_push;
  logic              w_pop;
  logic              w_rd_ack;

  always_comb begin
    w_empty       = (r_count == '0);
    w_full        = (r_count == CNT_FULL);
    w_wr_in_range = (wr_addr < FB_LIM);
    w_rd_in_range = (rd_addr < FB_LIM);
    w_force       = (r_starve == STARVE_MAX) && !w_empty;
    w_grant       = GNT_NONE;
    if (!reset) begin
      if (rd_req && !w_force) begin
        w_grant = GNT_READ;
      end else if (!w_empty) begin
        w_grant = GNT_WRITE;
      end
    end
    // Full is judged on pre-edge occupancy: a same-cycle pop never frees a slot.
    w_push   = wr_req && w_wr_in_range && !w_full;
    w_pop    = (w_grant == GNT_WRITE);
    w_rd_ack = (w_grant == GNT_READ);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= wr_addr;
      r_fifo_data[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (wr_req && w_wr_in_range && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_empty || (w_grant == GNT_WRITE)) begin
      r_starve <= '0;
    end else if ((w_grant == GNT_READ) && (r_starve != STARVE_MAX)) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_addr <= '0;
      r_ram_data <= 1'b0;
      r_ram_wren <= 1'b0;
    end else begin
      r_ram_wren <= 1'b0;
      case (w_grant)
        GNT_READ: begin
          if (w_rd_in_range) r_ram_addr <= rd_addr;
        end
        GNT_WRITE: begin
          r_ram_addr <= r_fifo_addr[r_rptr];
          r_ram_data <= r_fifo_data[r_rptr];
          r_ram_wren <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Stage 0: address registered; stage 1: RAM samples it; stage 2: ram_q captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld     <= '0;
      r_oor     <= '0;
      r_rd_data <= 1'b0;
    end else begin
      r_vld     <= {r_vld[1:0], w_rd_ack};
      r_oor     <= {r_oor[0], w_rd_ack && !w_rd_in_range};
      r_rd_data <= ram_q & ~r_oor[1];
    end
  end

  assign wr_full    = w_full;
  assign fifo_level = 3'(r_count);
  assign rd_ack     = w_rd_ack;
  assign rd_valid   = r_vld[2];
  assign rd_data    = r_rd_data;
  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign ram_wren   = r_ram_wren;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter with a behavioural single-port RAM
// (one-edge read latency, read-before-write).
module tb_fb_port_arbiter;
  localparam int ADDR_W = 18;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              wr_full;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic              rd_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_data;
  logic              ram_wren;
  logic              ram_q = 1'b0;
  logic              ovf;
  logic [2:0]        fifo_level;

  int checks = 0;
  int errors = 0;

  bit mem [0:(1<<ADDR_W)-1];

  fb_port_arbiter #(
    .ADDR_W(ADDR_W),
    .FB_SIZE(122400),
    .FIFO_DEPTH(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .ovf(ovf), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    reset   = 1'b0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_data = 1'b0;
    rd_req  = 1'b0;
    rd_addr = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; rd_req = 1'b1; rd_addr = 18'd9;
    wr_req = 1'b1; wr_addr = 18'd3; wr_data = 1'b1;
    @(negedge clk);
    checks++;
    if (rd_ack !== 1'b0) begin errors++; $display("FAIL reset_rd_ack got %b exp 0", rd_ack); end
    next_cycle();
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    checks++;
    if ({wr_full, ovf, rd_valid, rd_data} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got full/ovf/vld/data=%b exp 0000", {wr_full, ovf, rd_valid, rd_data});
    end
    checks++;
    if ({ram_wren, ram_data} !== 2'b00 || ram_addr !== '0) begin
      errors++; $display("FAIL reset_ram got wren=%b data=%b addr=%0d exp 0/0/0", ram_wren, ram_data, ram_addr);
    end
    next_cycle();
  endtask

  task automatic test_single;
    for (int c = 0; c < 10; c++) begin
      wr_req = (c == 0); wr_addr = 18'd100; wr_data = 1'b1;
      rd_req = (c == 4); rd_addr = 18'd100;
      @(negedge clk);
      checks++;
      if (rd_ack !== (c == 4)) begin errors++; $display("FAIL single_ack c=%0d got %b exp %b", c, rd_ack, c == 4); end
      checks++;
      if (ram_wren !== (c == 2)) begin errors++; $display("FAIL single_wren c=%0d got %b exp %b", c, ram_wren, c == 2); end
      checks++;
      if (rd_valid !== (c == 7)) begin errors++; $display("FAIL single_valid c=%0d got %b exp %b", c, rd_valid, c == 7); end
      checks++;
      if (fifo_level !== ((c == 1) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL single_level c=%0d got %0d exp %0d", c, fifo_level, (c == 1) ? 1 : 0);
      end
      if (c == 2) begin
        checks++;
        if (ram_addr !== 18'd100 || ram_data !== 1'b1) begin
          errors++; $display("FAIL single_ram_write got addr=%0d data=%b exp 100/1", ram_addr, ram_data);
        end
      end
      if (c == 7) begin
        checks++;
        if (rd_data !== 1'b1) begin errors++; $display("FAIL single_rd_data got %b exp 1", rd_data); end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_ordering;
    for (int c = 0; c < 7; c++) begin
      wr_req = (c < 3); wr_addr = 18'(10 + c); wr_data = (c != 1);
      @(negedge clk);
      checks++;
      if (ram_wren !== (c >= 2 && c <= 4)) begin
        errors++; $display("FAIL order_wren c=%0d got %b exp %b", c, ram_wren, c >= 2 && c <= 4);
      end
      checks++;
      if (fifo_level !== ((c >= 1 && c <= 3) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL order_level c=%0d got %0d exp %0d", c, fifo_level, (c >= 1 && c <= 3) ? 1 : 0);
      end
      if (c >= 2 && c <= 4) begin
        checks++;
        if (ram_addr !== 18'(8 + c) || ram_data !== (c != 3)) begin
          errors++; $display("FAIL order_ram c=%0d got addr=%0d data=%b exp %0d/%b", c, ram_addr, ram_data, 8 + c, c != 3);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_starvation;
    int n_ack = 0;
    int n_vld = 0;
    for (int c = 0; c < 21; c++) begin
      rd_req = (c <= 12); rd_addr = 18'd7;
      wr_req = (c == 0); wr_addr = 18'd300; wr_data = 1'b1;
      @(negedge clk);
      if (rd_ack === 1'b1) n_ack++;
      if (rd_valid === 1'b1) n_vld++;
      checks++;
      if (rd_ack !== (c <= 12 && c != 8)) begin
        errors++; $display("FAIL starve_ack c=%0d got %b exp %b", c, rd_ack, c <= 12 && c != 8);
      end
      checks++;
      if (rd_valid !== (c >= 3 && c <= 15 && c != 11)) begin
        errors++; $display("FAIL starve_valid c=%0d got %b exp %b", c, rd_valid, c >= 3 && c <= 15 && c != 11);
      end
      checks++;
      if (fifo_level !== ((c >= 1 && c <= 8) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL starve_level c=%0d got %0d exp %0d", c, fifo_level, (c >= 1 && c <= 8) ? 1 : 0);
      end
      checks++;
      if (ram_wren !== (c == 9)) begin errors++; $display("FAIL starve_wren c=%0d got %b exp %b", c, ram_wren, c == 9); end
      if (c == 9) begin
        checks++;
        if (ram_addr !== 18'd300) begin errors++; $display("FAIL starve_ram_addr got %0d exp 300", ram_addr); end
      end
      next_cycle();
    end
    checks++;
    if (n_ack != 12 || n_vld != n_ack) begin
      errors++; $display("FAIL starve_counts got ack=%0d valid=%0d exp 12/12", n_ack, n_vld);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    logic [ADDR_W-1:0] a [4];
    logic              d [4];
    a = '{18'd100, 18'd122400, 18'd101, 18'd300};
    d = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 9; c++) begin
      rd_req = (c < 4); rd_addr = a[c % 4];
      @(negedge clk);
      checks++;
      if (rd_ack !== (c < 4)) begin errors++; $display("FAIL b2b_ack c=%0d got %b exp %b", c, rd_ack, c < 4); end
      checks++;
      if (rd_valid !== (c >= 3 && c <= 6)) begin
        errors++; $display("FAIL b2b_valid c=%0d got %b exp %b", c, rd_valid, c >= 3 && c <= 6);
      end
      checks++;
      if (ram_wren !== 1'b0) begin errors++; $display("FAIL b2b_wren c=%0d got %b exp 0", c, ram_wren); end
      if (c >= 3 && c <= 6) begin
        checks++;
        if (rd_data !== d[c - 3]) begin errors++; $display("FAIL b2b_data c=%0d got %b exp %b", c, rd_data, d[c - 3]); end
      end
      if (c == 2) begin
        checks++;
        if (ram_addr !== 18'd100) begin errors++; $display("FAIL oor_ram_addr_hold got %0d exp 100", ram_addr); end
      end
      next_cycle();
    end
    idle_inputs();
    wr_req = 1'b1; wr_addr = 18'd122400; wr_data = 1'b1;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (fifo_level !== 3'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL oor_write got level=%0d ovf=%b exp 0/0", fifo_level, ovf);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ram_wren !== 1'b0) begin errors++; $display("FAIL oor_write_wren got %b exp 0", ram_wren); end
    next_cycle();
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic exp);
    rd_req = 1'b1; rd_addr = addr;
    @(negedge clk);
    checks++;
    if (rd_ack !== 1'b1) begin errors++; $display("FAIL read_ack addr=%0d got %b exp 1", addr, rd_ack); end
    next_cycle();
    rd_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (rd_valid !== (k == 3)) begin errors++; $display("FAIL read_valid addr=%0d k=%0d got %b exp %b", addr, k, rd_valid, k == 3); end
      if (k == 3) begin
        checks++;
        if (rd_data !== exp) begin errors++; $display("FAIL read_data addr=%0d got %b exp %b", addr, rd_data, exp); end
      end
      next_cycle();
    end
  endtask

  task automatic test_overflow;
    logic [2:0] exp_lvl;
    for (int c = 0; c < 10; c++) begin
      rd_req = (c <= 8); rd_addr = 18'd5;
      wr_req = (c <= 4) || (c == 8); wr_addr = 18'(200 + c); wr_data = 1'b1;
      exp_lvl = (c == 0) ? 3'd0 : (c <= 3) ? 3'(c) : (c <= 8) ? 3'd4 : 3'd3;
      @(negedge clk);
      checks++;
      if (fifo_level !== exp_lvl) begin errors++; $display("FAIL ovf_level c=%0d got %0d exp %0d", c, fifo_level, exp_lvl); end
      checks++;
      if (wr_full !== (exp_lvl == 3'd4)) begin errors++; $display("FAIL ovf_full c=%0d got %b exp %b", c, wr_full, exp_lvl == 3'd4); end
      checks++;
      if (ovf !== (c >= 5)) begin errors++; $display("FAIL ovf_flag c=%0d got %b exp %b", c, ovf, c >= 5); end
      checks++;
      if (rd_ack !== (c < 8)) begin errors++; $display("FAIL ovf_ack c=%0d got %b exp %b", c, rd_ack, c < 8); end
      if (c == 9) begin
        checks++;
        if (ram_wren !== 1'b1 || ram_addr !== 18'd200) begin
          errors++; $display("FAIL ovf_forced_write got wren=%b addr=%0d exp 1/200", ram_wren, ram_addr);
        end
      end
      next_cycle();
    end
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      if (fifo_level == 3'd0) break;
      next_cycle();
    end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drain got level=%0d exp 0", fifo_level); end
    next_cycle();
    next_cycle();
    do_read(18'd203, 1'b1);
    do_read(18'd204, 1'b0);
    do_read(18'd205, 1'b0);
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ovf); end
  endtask

  task automatic test_reset_midflight;
    for (int c = 0; c < 9; c++) begin
      reset  = (c == 3);
      rd_req = (c >= 1 && c <= 3); rd_addr = 18'(50 + c);
      wr_req = (c <= 2); wr_addr = 18'(400 + c); wr_data = 1'b1;
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL mid_ovf_before got %b exp 1", ovf); end
      end
      if (c == 3) begin
        checks++;
        if (rd_ack !== 1'b0 || fifo_level !== 3'd3) begin
          errors++; $display("FAIL mid_during_reset got ack=%b level=%0d exp 0/3", rd_ack, fifo_level);
        end
      end
      if (c >= 4) begin
        checks++;
        if ({rd_valid, ram_wren, ovf} !== 3'b000 || fifo_level !== 3'd0) begin
          errors++; $display("FAIL mid_after c=%0d got vld/wren/ovf=%b level=%0d exp 000/0", c, {rd_valid, ram_wren, ovf}, fifo_level);
        end
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_ordering();
    test_starvation();
    test_back_to_back();
    test_overflow();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
